npc_mem_arbiter: RTL and testbench
==================================

Name: npc_mem_arbiter

Overview:
- Shares the single-port instruction/data memory between the IFU (instruction fetch) and the LSU (load/store) of the NPC core.
- Enables the multi-cycle core in place of the combinational fetch/load path.
- Serialises requests into one outstanding memory transaction at a time.
- Routes each response back to the requester that owns the transaction.
- Provides a starvation guard and a response timeout.

Parameters:
- DATA_LEN, 32, address and data width; wmask width is DATA_LEN/8.
- STARVE_MAX, 4, number of consecutive LSU grants while IFU waits before IFU is forced to win; 0 disables the guard.
- TIMEOUT, 255, number of cycles in WAIT without mem_resp_valid before an error response is generated; 0 disables the timeout.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  DATA_LEN  fetch address
- ifu_resp_valid  out  1  response for the IFU, single-cycle pulse
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  DATA_LEN  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_LEN  store data
- lsu_wmask  in  DATA_LEN/8  byte enables
- lsu_resp_valid  out  1  response for the LSU, single-cycle pulse
- resp_rdata  out  DATA_LEN  read data shared by both requesters; valid only alongside a resp_valid
- resp_err  out  1  timeout error, qualified by a resp_valid
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream request accepted
- mem_addr  out  DATA_LEN  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DATA_LEN  latched write data
- mem_wmask  out  DATA_LEN/8  latched byte enables
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DATA_LEN  downstream read data

Behaviour:
- Reset (async, sys_rst_n low):
  - State = IDLE; starve counter and timer = 0.
  - All outputs = 0.
  - An in-flight transaction is abandoned; no response is issued after reset is released.
- FSM states: IDLE, ISSUE, WAIT, RESP. Every output is registered, except that req_ready is a combinational decode of IDLE plus the arbitration result.
- IDLE, arbitration:
  - Winner is the LSU whenever lsu_req_valid is high.
  - Exception: if ifu_req_valid is high and starve == STARVE_MAX (STARVE_MAX != 0), the IFU wins.
  - The winner's req_ready = 1; the loser's = 0.
  - On handshake, latch addr/wen/wdata/wmask and the owner, then go to ISSUE. IFU requests latch wen = 0, wmask = all ones, wdata = 0.
- Starve counter:
  - Increments when the LSU wins while ifu_req_valid is high.
  - Clears when the IFU wins.
  - Clears on any LSU win without IFU pending.
  - Saturates at STARVE_MAX.
- ISSUE:
  - mem_req_valid = 1; mem_* fields are held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to WAIT and clear the timer. mem_req_valid drops the next cycle.
- WAIT:
  - On mem_resp_valid: latch mem_rdata, set err = 0, go to RESP.
  - Otherwise the timer increments.
  - When the timer reaches TIMEOUT-1 with no response (TIMEOUT != 0): rdata = 0, err = 1, go to RESP.
- RESP:
  - The owner's resp_valid = 1 for exactly one cycle; resp_rdata and resp_err are valid.
  - Requesters have no backpressure and must consume the pulse.
  - Next cycle: IDLE.
- mem_resp_valid is ignored in every state other than WAIT. A late response after a timeout is therefore discarded.
- req_ready is 0 in ISSUE/WAIT/RESP. A requester keeps valid and its fields stable until its ready.
- Latency: accept at cycle T, mem_req_valid at T+1.
  - With mem_req_ready at T+1 and mem_resp_valid at T+2, resp_valid is at T+3.
  - Maximum throughput is one transaction per 4 cycles.
- The response owner is always the latched owner, never the current valids.

Decomposition:
- Shared package npc_bus_pkg:
  - FSM state enum.
  - Owner encoding (OWN_IFU = 0, OWN_LSU = 1).
  - Default constants for STARVE_MAX/TIMEOUT.
- One natural sub-module, npc_prio_pick: the 2-way LSU-priority picker with the saturating starvation counter. Outputs grant_ifu/grant_lsu.

Test Plan:
- IFU fetch alone:
  - Stimulus: ifu_addr 0x80000000; mem ready immediately; mem_rdata 0x00100073 one cycle later.
  - Required: ifu_resp_valid at accept+3, resp_rdata 0x00100073, resp_err 0, lsu_resp_valid never 1.
- Simultaneous IFU and LSU at IDLE:
  - Stimulus: IFU 0x80000004; LSU store 0x80001000, wdata 0xDEADBEEF, wmask 0xF.
  - Required: LSU served first with mem_wen 1 and those fields; the IFU fetch is issued afterwards with mem_wen 0 and mem_wmask 0xF.
- Starvation guard:
  - Stimulus: STARVE_MAX 2; both requesters held valid for 9 transactions.
  - Required: grant order L,L,I,L,L,I,L,L,I.
- Timeout:
  - Stimulus: TIMEOUT 16; memory never responds; mem_resp_valid then pulses 3 cycles later.
  - Required: owner resp_valid with resp_err 1 and resp_rdata 0 exactly 16 cycles after entering WAIT; the late response is ignored, with no second resp_valid.
- Backpressure:
  - Stimulus: mem_req_ready low for 5 cycles while both requesters are valid.
  - Required: mem_req_valid stays high, mem_addr/mem_wdata stable, both req_ready 0 throughout.
- Reset in the middle of WAIT:
  - Stimulus: sys_rst_n asserted.
  - Required: all outputs 0 immediately (asynchronously); after release, state is IDLE and no resp_valid appears for the abandoned transaction.

Source files
------------

// File: rtl/npc_bus_pkg.sv
// Shared types and defaults for the NPC memory arbiter slice.
// Holds the FSM state encoding, owner encoding and counter sizing helper.
package npc_bus_pkg;

  localparam int DATA_LEN_DEF   = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Bits needed to hold 0..maxval; never narrower than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval > 1) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// Bundles the IFU, LSU and downstream memory handshakes of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface npc_mem_arbiter_if import npc_bus_pkg::*; #(
  parameter int DATA_LEN = DATA_LEN_DEF
) ();

  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [DATA_LEN-1:0]     ifu_addr;
  logic                    ifu_resp_valid;

  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic [DATA_LEN-1:0]     lsu_addr;
  logic                    lsu_wen;
  logic [DATA_LEN-1:0]     lsu_wdata;
  logic [DATA_LEN/8-1:0]   lsu_wmask;
  logic                    lsu_resp_valid;

  logic [DATA_LEN-1:0]     resp_rdata;
  logic                    resp_err;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [DATA_LEN-1:0]     mem_addr;
  logic                    mem_wen;
  logic [DATA_LEN-1:0]     mem_wdata;
  logic [DATA_LEN/8-1:0]   mem_wmask;
  logic                    mem_resp_valid;
  logic [DATA_LEN-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid,
    output lsu_req_ready, lsu_resp_valid,
    output resp_rdata, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid,
    input  lsu_req_ready, lsu_resp_valid,
    input  resp_rdata, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/npc_prio_pick.sv
// Two-way picker: LSU wins by default, IFU is forced through after
// STARVE_MAX consecutive LSU wins while it was waiting.
module npc_prio_pick import npc_bus_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic arb_en_i,
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_ifu_o,
  output logic grant_lsu_o
);

  localparam int SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          force_ifu;
  logic          grant_ifu;
  logic          grant_lsu;
  logic          starve_full;

  always_comb begin
    starve_full = (starve_q == SW'(STARVE_MAX));
    force_ifu   = (STARVE_MAX != 0) && ifu_valid_i && starve_full;
    grant_lsu   = lsu_valid_i && !force_ifu;
    grant_ifu   = ifu_valid_i && !grant_lsu;
    starve_d    = starve_q;
    // Counter only moves when a grant is actually taken in IDLE.
    if (arb_en_i) begin
      if (grant_ifu) begin
        starve_d = '0;
      end else if (grant_lsu) begin
        if (!ifu_valid_i) begin
          starve_d = '0;
        end else if (!starve_full) begin
          starve_d = starve_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign grant_ifu_o = grant_ifu;
  assign grant_lsu_o = grant_lsu;

endmodule

// File: rtl/npc_mem_arbiter.sv
// Serialises IFU and LSU requests onto the single-port memory, one
// outstanding transaction at a time, with a response timeout.
module npc_mem_arbiter import npc_bus_pkg::*; #(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  npc_mem_arbiter_if.slave bus
);

  localparam int MW = DATA_LEN / 8;
  localparam int TW = cnt_width(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [DATA_LEN-1:0]   mem_addr_q, mem_addr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [DATA_LEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]         mem_wmask_q, mem_wmask_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  ifu_resp_valid_q, ifu_resp_valid_d;
  logic                  lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic arb_idle;
  logic grant_ifu;
  logic grant_lsu;
  logic timed_out;

  assign arb_idle = (state_q == ST_IDLE);

  npc_prio_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .arb_en_i    (arb_idle),
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  // Gated by reset so the ready outputs also read 0 while reset is held.
  assign bus.ifu_req_ready = sys_rst_n && arb_idle && grant_ifu;
  assign bus.lsu_req_ready = sys_rst_n && arb_idle && grant_lsu;

  assign timed_out = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_wen_d        = mem_wen_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wmask_d      = mem_wmask_q;
    timer_d          = timer_q;
    ifu_resp_valid_d = 1'b0;
    lsu_resp_valid_d = 1'b0;
    rdata_d          = rdata_q;
    err_d            = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          owner_d         = OWN_LSU;
          mem_addr_d      = bus.lsu_addr;
          mem_wen_d       = bus.lsu_wen;
          mem_wdata_d     = bus.lsu_wdata;
          mem_wmask_d     = bus.lsu_wmask;
          mem_req_valid_d = 1'b1;
          state_d         = ST_ISSUE;
        end else if (grant_ifu) begin
          owner_d         = OWN_IFU;
          mem_addr_d      = bus.ifu_addr;
          mem_wen_d       = 1'b0;
          mem_wdata_d     = '0;
          mem_wmask_d     = '1;
          mem_req_valid_d = 1'b1;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          timer_d         = '0;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A real response takes precedence over a timeout in the same cycle.
        if (bus.mem_resp_valid || timed_out) begin
          rdata_d          = bus.mem_resp_valid ? bus.mem_rdata : '0;
          err_d            = !bus.mem_resp_valid;
          ifu_resp_valid_d = (owner_q == OWN_IFU);
          lsu_resp_valid_d = (owner_q == OWN_LSU);
          state_d          = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_IFU;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_wen_q        <= 1'b0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      timer_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      rdata_q          <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_wen_q        <= mem_wen_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wmask_q      <= mem_wmask_d;
      timer_q          <= timer_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      rdata_q          <= rdata_d;
      err_q            <= err_d;
    end
  end

  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wmask      = mem_wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = err_q;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed bench for npc_mem_arbiter with STARVE_MAX=2 and TIMEOUT=16.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_npc_mem_arbiter;

  logic sys_clk;
  logic sys_rst_n;
  int   assertCount;
  int   failCount;
  string expOrder;

  npc_mem_arbiter_if #(.DATA_LEN(32)) bus ();

  npc_mem_arbiter #(
    .DATA_LEN   (32),
    .STARVE_MAX (2),
    .TIMEOUT    (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifuV, input logic [31:0] ifuA,
                               input logic lsuV, input logic [31:0] lsuA,
                               input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wmask);
    bus.ifu_req_valid = ifuV;
    bus.ifu_addr      = ifuA;
    bus.lsu_req_valid = lsuV;
    bus.lsu_addr      = lsuA;
    bus.lsu_wen       = wen;
    bus.lsu_wdata     = wdata;
    bus.lsu_wmask     = wmask;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    sys_rst_n   = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;

    #12;
    checkOutput("rst_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst_ifu_resp", bus.ifu_resp_valid, 0);
    checkOutput("rst_lsu_resp", bus.lsu_resp_valid, 0);
    checkOutput("rst_rdata", bus.resp_rdata, 0);
    checkOutput("rst_err", bus.resp_err, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    tick();
    #2 sys_rst_n = 1'b1;
    tick();

    $display("[TB] IFU fetch alone");
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("t1_ifu_ready", bus.ifu_req_ready, 1);
    checkOutput("t1_lsu_ready", bus.lsu_req_ready, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("t1_mem_req_valid", bus.mem_req_valid, 1);
    checkOutput("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
    checkOutput("t1_mem_wen", bus.mem_wen, 0);
    checkOutput("t1_mem_wmask", bus.mem_wmask, 4'hF);
    checkOutput("t1_mem_wdata", bus.mem_wdata, 0);
    tick();
    checkOutput("t1_mem_req_drop", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0010_0073;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkOutput("t1_ifu_resp", bus.ifu_resp_valid, 1);
    checkOutput("t1_lsu_resp", bus.lsu_resp_valid, 0);
    checkOutput("t1_rdata", bus.resp_rdata, 32'h0010_0073);
    checkOutput("t1_err", bus.resp_err, 0);
    tick();
    checkOutput("t1_ifu_resp_pulse", bus.ifu_resp_valid, 0);
    checkOutput("t1_lsu_resp_after", bus.lsu_resp_valid, 0);

    $display("[TB] simultaneous IFU and LSU");
    applyStimulus(1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    #1;
    checkOutput("t2_lsu_ready", bus.lsu_req_ready, 1);
    checkOutput("t2_ifu_ready", bus.ifu_req_ready, 0);
    tick();
    applyStimulus(1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("t2_mem_wen_st", bus.mem_wen, 1);
    checkOutput("t2_mem_addr_st", bus.mem_addr, 32'h8000_1000);
    checkOutput("t2_mem_wdata_st", bus.mem_wdata, 32'hDEAD_BEEF);
    checkOutput("t2_mem_wmask_st", bus.mem_wmask, 4'hF);
    #1;
    checkOutput("t2_ifu_ready_busy", bus.ifu_req_ready, 0);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkOutput("t2_lsu_resp", bus.lsu_resp_valid, 1);
    checkOutput("t2_ifu_resp_none", bus.ifu_resp_valid, 0);
    tick();
    checkOutput("t2_ifu_ready_next", bus.ifu_req_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("t2_mem_wen_ld", bus.mem_wen, 0);
    checkOutput("t2_mem_addr_ld", bus.mem_addr, 32'h8000_0004);
    checkOutput("t2_mem_wmask_ld", bus.mem_wmask, 4'hF);
    checkOutput("t2_mem_wdata_ld", bus.mem_wdata, 0);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkOutput("t2_ifu_resp", bus.ifu_resp_valid, 1);
    checkOutput("t2_ifu_rdata", bus.resp_rdata, 32'h1234_5678);
    tick();

    $display("[TB] starvation guard");
    expOrder = "LLILLILLI";
    applyStimulus(1'b1, 32'h8000_0100, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'hF);
    #1;
    for (int t = 0; t < 9; t++) begin
      checkOutput($sformatf("t3_ifu_ready_%0d", t), bus.ifu_req_ready, (expOrder[t] == "I") ? 1 : 0);
      checkOutput($sformatf("t3_lsu_ready_%0d", t), bus.lsu_req_ready, (expOrder[t] == "L") ? 1 : 0);
      tick();
      checkOutput($sformatf("t3_mem_addr_%0d", t), bus.mem_addr,
                  (expOrder[t] == "I") ? 32'h8000_0100 : 32'h8000_2000);
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0000_0100 + t;
      tick();
      bus.mem_resp_valid = 1'b0;
      checkOutput($sformatf("t3_ifu_resp_%0d", t), bus.ifu_resp_valid, (expOrder[t] == "I") ? 1 : 0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick();

    $display("[TB] timeout");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'hF);
    #1;
    checkOutput("t4_lsu_ready", bus.lsu_req_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick();
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t4_no_resp_w%0d", k), bus.lsu_resp_valid, 0);
      tick();
    end
    checkOutput("t4_lsu_resp", bus.lsu_resp_valid, 1);
    checkOutput("t4_err", bus.resp_err, 1);
    checkOutput("t4_rdata", bus.resp_rdata, 0);
    checkOutput("t4_ifu_resp", bus.ifu_resp_valid, 0);
    tick();
    tick();
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFE_F00D;
    tick();
    bus.mem_resp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_late_lsu_%0d", k), bus.lsu_resp_valid, 0);
      checkOutput($sformatf("t4_late_ifu_%0d", k), bus.ifu_resp_valid, 0);
      tick();
    end

    $display("[TB] backpressure");
    bus.mem_req_ready = 1'b0;
    applyStimulus(1'b1, 32'h8000_0200, 1'b1, 32'h8000_4000, 1'b1, 32'hA5A5_A5A5, 4'h3);
    #1;
    checkOutput("t5_lsu_ready", bus.lsu_req_ready, 1);
    tick();
    applyStimulus(1'b1, 32'h8000_0200, 1'b1, 32'h8000_4004, 1'b1, 32'h5A5A_5A5A, 4'hC);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t5_req_valid_%0d", i), bus.mem_req_valid, 1);
      checkOutput($sformatf("t5_addr_%0d", i), bus.mem_addr, 32'h8000_4000);
      checkOutput($sformatf("t5_wdata_%0d", i), bus.mem_wdata, 32'hA5A5_A5A5);
      checkOutput($sformatf("t5_ifu_ready_%0d", i), bus.ifu_req_ready, 0);
      checkOutput($sformatf("t5_lsu_ready_%0d", i), bus.lsu_req_ready, 0);
      tick();
    end
    checkOutput("t5_req_valid_end", bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    tick();
    checkOutput("t5_req_valid_drop", bus.mem_req_valid, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1122_3344;
    tick();
    bus.mem_resp_valid = 1'b0;
    checkOutput("t5_lsu_resp", bus.lsu_resp_valid, 1);
    tick();
    checkOutput("t5_lsu_ready_again", bus.lsu_req_ready, 1);
    tick();
    applyStimulus(1'b1, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("t5_addr2", bus.mem_addr, 32'h8000_4004);
    checkOutput("t5_wdata2", bus.mem_wdata, 32'h5A5A_5A5A);
    tick();
    checkOutput("t6_in_wait", bus.mem_req_valid, 0);

    $display("[TB] reset during WAIT");
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("t6_mem_addr", bus.mem_addr, 0);
    checkOutput("t6_mem_wen", bus.mem_wen, 0);
    checkOutput("t6_mem_wdata", bus.mem_wdata, 0);
    checkOutput("t6_mem_wmask", bus.mem_wmask, 0);
    checkOutput("t6_rdata", bus.resp_rdata, 0);
    checkOutput("t6_err", bus.resp_err, 0);
    checkOutput("t6_ifu_resp", bus.ifu_resp_valid, 0);
    checkOutput("t6_lsu_resp", bus.lsu_resp_valid, 0);
    checkOutput("t6_ifu_ready", bus.ifu_req_ready, 0);
    checkOutput("t6_lsu_ready", bus.lsu_req_ready, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #2 sys_rst_n = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_BAD0;
    tick();
    bus.mem_resp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t6_stale_lsu_%0d", k), bus.lsu_resp_valid, 0);
      checkOutput($sformatf("t6_stale_ifu_%0d", k), bus.ifu_resp_valid, 0);
      checkOutput($sformatf("t6_stale_req_%0d", k), bus.mem_req_valid, 0);
      tick();
    end
    applyStimulus(1'b1, 32'h8000_0300, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("t6_idle_ifu_ready", bus.ifu_req_ready, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkOutput("t6_new_req_valid", bus.mem_req_valid, 1);
    checkOutput("t6_new_addr", bus.mem_addr, 32'h8000_0300);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
